// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - pushbutton synchronizer, debouncer and auto-repeat event generator
//
// Purpose:
//   Turns raw active-low pushbuttons into a clean debounced level plus
//   single-cycle press, release and auto-repeat event pulses. Each channel
//   is independent and identical.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   btn_n        raw buttons, active-low, asynchronous to clk
//   btn_level    debounced state, 1 = pressed
//   btn_press    one-cycle pulse when btn_level rises
//   btn_release  one-cycle pulse when btn_level falls
//   btn_evt      one-cycle pulse on each press and on each auto-repeat

module btn_conditioner #(
    parameter int N_BTN     = 3,
    parameter int DB_CYCLES = 500000,
    parameter int REP_DELAY = 25000000,
    parameter int REP_RATE  = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_evt
);

    localparam int DB_W    = $clog2(DB_CYCLES) + 1;
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'((REP_DELAY > 0) ? REP_DELAY - 1 : 0);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REP_RATE - 1);
    localparam bit               REP_EN     = (REP_DELAY > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rep_state_t;

    // Two-flop synchronizer; flops reset to 1 so the channel starts released.
    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;
    logic [N_BTN-1:0] w_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= btn_n;
            r_s2 <= r_s1;
        end
    end

    assign w_sync = ~r_s2;

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_ch
            logic [DB_W-1:0]  r_db_cnt;
            logic             r_level;
            logic             r_press;
            logic             r_release;
            logic             r_evt;
            rep_state_t       r_state;
            logic [REP_W-1:0] r_rep_cnt;
            logic             w_change;
            logic             w_rise;
            logic             w_fall;

            // The level flips on the cycle the disagreement run completes;
            // the same condition drives the registered edge pulses.
            assign w_change = (w_sync[g] != r_level) && (r_db_cnt == DB_LAST);
            assign w_rise   = w_change && w_sync[g];
            assign w_fall   = w_change && !w_sync[g];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_db_cnt  <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_press   <= w_rise;
                    r_release <= w_fall;
                    if (w_sync[g] == r_level) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_level  <= w_sync[g];
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            // Auto-repeat: release always returns to IDLE and suppresses any
            // repeat pulse that would land on the same edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state   <= ST_IDLE;
                    r_rep_cnt <= '0;
                    r_evt     <= 1'b0;
                end else begin
                    r_evt <= w_rise;
                    if (w_fall) begin
                        r_state   <= ST_IDLE;
                        r_rep_cnt <= '0;
                    end else begin
                        case (r_state)
                            ST_IDLE: begin
                                if (w_rise && REP_EN) begin
                                    r_state   <= ST_DELAY;
                                    r_rep_cnt <= '0;
                                end
                            end
                            ST_DELAY: begin
                                if (r_rep_cnt == DELAY_LAST) begin
                                    r_evt     <= 1'b1;
                                    r_rep_cnt <= '0;
                                    r_state   <= ST_REPEAT;
                                end else begin
                                    r_rep_cnt <= r_rep_cnt + 1'b1;
                                end
                            end
                            ST_REPEAT: begin
                                if (r_rep_cnt == RATE_LAST) begin
                                    r_evt     <= 1'b1;
                                    r_rep_cnt <= '0;
                                end else begin
                                    r_rep_cnt <= r_rep_cnt + 1'b1;
                                end
                            end
                            default: begin
                                r_state   <= ST_IDLE;
                                r_rep_cnt <= '0;
                            end
                        endcase
                    end
                end
            end

            assign btn_level[g]   = r_level;
            assign btn_press[g]   = r_press;
            assign btn_release[g] = r_release;
            assign btn_evt[g]     = r_evt;
        end
    endgenerate

endmodule
